// File: rtl/modport_dff_pkg.sv
// ---------------------------------------------------------------------------
// modport_dff_pkg
//   Shared constants and types for the modport_dff storage element.
//   DFF_WIDTH_DEFAULT   : default data width of the flop
//   DFF_RST_VAL_DEFAULT : default per-bit reset value
//   dff_data_t          : data word type at the default width
// ---------------------------------------------------------------------------
package modport_dff_pkg;

    localparam int   DFF_WIDTH_DEFAULT   = 1;
    localparam logic DFF_RST_VAL_DEFAULT = 1'b0;

    typedef logic [DFF_WIDTH_DEFAULT-1:0] dff_data_t;

endpackage : modport_dff_pkg

// File: rtl/modport_dff_bit_cell.sv
// ---------------------------------------------------------------------------
// dff_bit_cell
//   One-bit D flop with asynchronous active-low reset and a per-bit reset
//   value.
//   Ports:
//     clk : clock, rising edge active
//     rst : asynchronous reset, active-low (0 forces q to RST_BIT)
//     d   : data in, captured on rising clk
//     q   : registered data out
// ---------------------------------------------------------------------------
module dff_bit_cell
    import modport_dff_pkg::*;
#(
    parameter logic RST_BIT = DFF_RST_VAL_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    // A release that coincides with a rising edge is still seen as reset
    // active by this edge, so capture starts on the following edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q <= RST_BIT;
        else      q <= d;
    end

endmodule : dff_bit_cell

// File: rtl/modport_dff.sv
// ---------------------------------------------------------------------------
// modport_dff
//   WIDTH-bit D flip-flop with asynchronous active-low reset. Pure storage:
//   no enable, no combinational path from d to q. X/Z on d propagates to q.
//   Parameters:
//     WIDTH   : data width
//     RST_VAL : value forced onto q while rst is low
//   Ports:
//     clk : clock, rising edge active
//     rst : asynchronous reset, active-low
//     d   : data in [WIDTH]
//     q   : registered data out [WIDTH]
// ---------------------------------------------------------------------------
module modport_dff
    import modport_dff_pkg::*;
#(
    parameter int               WIDTH   = DFF_WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{DFF_RST_VAL_DEFAULT}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // One cell per bit so each bit carries its own reset value.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff_bit_cell #(
            .RST_BIT (RST_VAL[i])
        ) u_cell (
            .clk (clk),
            .rst (rst),
            .d   (d[i]),
            .q   (q[i])
        );
    end

endmodule : modport_dff

// File: tb/tb_modport_dff.sv
// ---------------------------------------------------------------------------
// tb_modport_dff
//   Directed bench for modport_dff at the default width. Data is driven on
//   the falling edge and q is sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_modport_dff;
    import modport_dff_pkg::*;

    localparam int WIDTH = DFF_WIDTH_DEFAULT;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;

    int checks = 0;
    int errors = 0;

    modport_dff #(
        .WIDTH   (WIDTH),
        .RST_VAL ('0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .d   (d),
        .q   (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input dff_data_t obs, input dff_data_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: q=%b expected %b", tag, obs, exp);
        end
    endtask

    // Drive d on the falling edge, then sample q just after the next rising edge.
    task automatic step(input dff_data_t val);
        @(negedge clk);
        d = val;
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        dff_data_t stream [5];
        dff_data_t prev;
        stream = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        // 1. Power-up: assert reset before any edge, hold 3 cycles with d=1.
        rst = 1'b1;
        d   = 1'b1;
        #2 rst = 1'b0;
        #1 check("reset_async_powerup", q, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 check("reset_hold", q, 1'b0);
        end
        @(negedge clk);
        rst = 1'b1;
        #1 check("release_no_change", q, 1'b0);
        @(posedge clk);
        #1 check("first_capture", q, 1'b1);

        // 2. Capture 0 then 1 then 0.
        step(1'b0); check("capture_0", q, 1'b0);
        step(1'b1); check("capture_1", q, 1'b1);
        step(1'b0); check("capture_0b", q, 1'b0);

        // 3. Toggle stream: q before each edge is the previous value.
        prev = 1'b0;
        foreach (stream[i]) begin
            @(negedge clk);
            d = stream[i];
            #1 check("stream_pre_edge", q, prev);
            @(posedge clk);
            #1 check("stream_post_edge", q, stream[i]);
            prev = stream[i];
        end

        // 4. Async reset mid-cycle with q=1.
        step(1'b1); check("pre_reset_q1", q, 1'b1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check("async_reset_midcycle", q, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1 check("async_reset_hold", q, 1'b0);
        end

        // 6. Release coincident with a rising edge while d=1. The release is
        //    scheduled as an update after this edge's evaluation, so the edge
        //    deterministically sees reset still active.
        @(posedge clk);
        rst <= 1'b1;
        #1 check("release_at_edge_no_capture", q, 1'b0);
        @(posedge clk);
        #1 check("release_at_edge_next_capture", q, 1'b1);

        // 5. Glitch immunity: d pulses high between edges, low at the edge.
        step(1'b0); check("glitch_setup", q, 1'b0);
        @(negedge clk);
        #1 d = 1'b1;
        #2 d = 1'b0;
        check("glitch_between_edges", q, 1'b0);
        @(posedge clk);
        #1 check("glitch_not_captured", q, 1'b0);

        // X on d propagates unmasked.
        step(1'bx); check("x_propagation", q, 1'bx);
        step(1'b1); check("recover_from_x", q, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guard against a stalled run.
    initial begin : watchdog
        #20000;
        errors++;
        $display("FAIL watchdog: time limit reached, expected stimulus to complete");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule : tb_modport_dff
